// File: rtl/redbus_pkg.sv
// redbus_pkg
//   Shared definitions for the redbus console endpoint: register window
//   addresses (decoded from Address[7:0]), STATUS bit positions, the CTRL
//   loopback bit, and a helper that packs the STATUS byte.
//   No ports (package).
package redbus_pkg;

    localparam logic [7:0] REG_STATUS  = 8'h00;
    localparam logic [7:0] REG_RXCOUNT = 8'h01;
    localparam logic [7:0] REG_RXDATA  = 8'h02;
    localparam logic [7:0] REG_TXDATA  = 8'h03;
    localparam logic [7:0] REG_TXCOUNT = 8'h04;
    localparam logic [7:0] REG_CTRL    = 8'h05;

    localparam int STAT_RX_NONEMPTY = 0;
    localparam int STAT_TX_FULL     = 1;
    localparam int STAT_RX_OVF      = 2;
    localparam int STAT_TX_DROP     = 3;

    localparam int CTRL_LOOPBACK = 0;

    function automatic logic [7:0] status_byte(input logic rx_nonempty,
                                               input logic tx_full,
                                               input logic rx_ovf,
                                               input logic tx_drop);
        logic [7:0] s;
        s                   = 8'h00;
        s[STAT_RX_NONEMPTY] = rx_nonempty;
        s[STAT_TX_FULL]     = tx_full;
        s[STAT_RX_OVF]      = rx_ovf;
        s[STAT_TX_DROP]     = tx_drop;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with occupancy count. A push into a full FIFO is
//   accepted only when a pop happens in the same cycle; a pop on an empty
//   FIFO is ignored. Storage is not reset; pointers and count are.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, din      write request and data
//   pop            read request (head advances at the clock edge)
//   dout           current head entry (meaningful only when !empty)
//   count          occupancy, $clog2(DEPTH)+1 bits
//   full, empty    occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // Pop frees the slot first, so a push against a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/redbus_console.sv
// redbus_console
//   Redbus target exposing a console byte stream: an RX FIFO fed by RxStrobe
//   and read by the CPU, and a TX FIFO written by the CPU and drained by the
//   downstream TxValid/TxReady handshake.
//   Optional feature macro: REDBUS_CONSOLE_LOOPBACK_EN (CTRL bit0 loops TX
//   bytes back into RX; without it CTRL reads 0x00 and ignores writes).
// Ports:
//   Clock, Reset          clock, asynchronous active-low reset
//   Address[15:0]         byte address, only [7:0] decoded
//   Data[7:0]             bidirectional bus, driven only on a matched read
//   RedbusDevice[7:0]     target device number
//   Read, Write           access strobes (side effects on rising edge only)
//   RxStrobe, RxData      incoming byte, one-cycle pulse, no backpressure
//   TxValid, TxData       outgoing byte (TX FIFO head)
//   TxReady               downstream accepts TxData
module redbus_console
    import redbus_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID = 8'h01,
    parameter int         RX_DEPTH  = 16,
    parameter int         TX_DEPTH  = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Address,
    inout  wire  [7:0]  Data,
    input  logic [7:0]  RedbusDevice,
    input  logic        Read,
    input  logic        Write,
    input  logic        RxStrobe,
    input  logic [7:0]  RxData,
    output logic        TxValid,
    output logic [7:0]  TxData,
    input  logic        TxReady
);

    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    logic [7:0]       addr;
    logic             unused_addr_hi;
    logic             match;
    logic             read_q, write_q;
    logic             rd_blk, wr_blk;
    logic             rd_start, wr_start, wr_any;
    logic             rd_latched;
    logic [7:0]       rd_latch;
    logic [7:0]       rd_comb;
    logic [7:0]       ctrl_byte;

    logic             rx_push, rx_pop, rx_full, rx_empty, rx_drop;
    logic [7:0]       rx_din, rx_dout;
    logic [RX_CW-1:0] rx_count;
    logic             tx_push, tx_pop, tx_full, tx_empty, tx_drop;
    logic [7:0]       tx_dout;
    logic [TX_CW-1:0] tx_count;
    logic             rx_ovf, tx_dropped;

    assign addr           = Address[7:0];
    assign unused_addr_hi = ^Address[15:8];
    assign match          = (RedbusDevice == DEVICE_ID);

    // rd_blk/wr_blk come out of reset set so that a strobe already high when
    // reset is released cannot produce a start; they clear once it drops.
    assign rd_start = Read  & ~read_q  & ~rd_blk;
    assign wr_start = Write & ~write_q & ~wr_blk;
    assign wr_any   = wr_start & match;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            rd_blk     <= 1'b1;
            wr_blk     <= 1'b1;
            rd_latched <= 1'b0;
        end else begin
            read_q  <= Read;
            write_q <= Write;
            rd_blk  <= rd_blk & Read;
            wr_blk  <= wr_blk & Write;
            if (rd_start) begin
                rd_latched <= 1'b1;
            end else if (!Read) begin
                rd_latched <= 1'b0;
            end
        end
    end

    // The first strobe cycle shows live state; the value is captured then so
    // a pop at that edge does not change what the initiator sees afterwards.
    always_ff @(posedge Clock) begin
        if (rd_start) begin
            rd_latch <= rd_comb;
        end
    end

    always_comb begin
        rd_comb = 8'h00;
        case (addr)
            REG_STATUS:  rd_comb = status_byte(~rx_empty, tx_full, rx_ovf, tx_dropped);
            REG_RXCOUNT: rd_comb = 8'(rx_count);
            REG_RXDATA:  rd_comb = rx_empty ? 8'h00 : rx_dout;
            REG_TXCOUNT: rd_comb = 8'(tx_count);
            REG_CTRL:    rd_comb = ctrl_byte;
            default:     rd_comb = 8'h00;
        endcase
    end

    assign Data = (Read && match) ? (rd_latched ? rd_latch : rd_comb) : {8{1'bz}};

    assign tx_push = wr_any & (addr == REG_TXDATA);
    assign rx_pop  = rd_start & match & (addr == REG_RXDATA);

`ifdef REDBUS_CONSOLE_LOOPBACK_EN
    logic ctrl_lb;
    logic lb_xfer;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ctrl_lb <= 1'b0;
        end else if (wr_any && (addr == REG_CTRL)) begin
            ctrl_lb <= Data[CTRL_LOOPBACK];
        end
    end

    assign ctrl_byte = {7'b0, ctrl_lb};
    // In loopback the TX head moves into RX every cycle; the external input
    // loses the RX write port and a coincident RxStrobe counts as overflow.
    assign lb_xfer   = ctrl_lb & ~tx_empty;
    assign tx_pop    = ctrl_lb ? lb_xfer : TxReady;
    assign rx_push   = ctrl_lb ? lb_xfer : RxStrobe;
    assign rx_din    = ctrl_lb ? tx_dout : RxData;
    assign TxValid   = ~tx_empty & ~ctrl_lb;
    assign rx_drop   = (rx_push & rx_full & ~rx_pop) | (lb_xfer & RxStrobe);
`else
    assign ctrl_byte = 8'h00;
    assign tx_pop    = TxReady;
    assign rx_push   = RxStrobe;
    assign rx_din    = RxData;
    assign TxValid   = ~tx_empty;
    assign rx_drop   = rx_push & rx_full & ~rx_pop;
`endif

    assign tx_drop = tx_push & tx_full & ~tx_pop;
    assign TxData  = tx_empty ? 8'h00 : tx_dout;

    // Any matched write clears the sticky bits; a new event in the same
    // cycle wins so it is never lost.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_ovf     <= 1'b0;
            tx_dropped <= 1'b0;
        end else begin
            rx_ovf     <= (rx_ovf & ~wr_any) | rx_drop;
            tx_dropped <= (tx_dropped & ~wr_any) | tx_drop;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (Clock),
        .rst_n (Reset),
        .push  (rx_push),
        .din   (rx_din),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (Clock),
        .rst_n (Reset),
        .push  (tx_push),
        .din   (Data),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

endmodule

// File: tb/tb_redbus_console.sv
// tb_redbus_console
//   Directed bench for redbus_console (DEVICE_ID 0x01, 16-entry FIFOs).
//   A vector table covers decode, matching and basic RX behaviour; hand
//   sequences cover held strobes, FIFO full/overflow, mid-strobe reset and
//   the CTRL register.
module tb_redbus_console;

    localparam int OP_RD = 0;  // matched read, compare Data
    localparam int OP_RU = 1;  // unmatched read, bench holds bus at 0x00
    localparam int OP_WR = 2;  // write
    localparam int OP_RX = 3;  // RxStrobe pulse

    typedef struct {
        int         op;
        logic [7:0] a;
        logic [7:0] dev;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  dev;
    logic        rd, wr, rxs, txr;
    logic [7:0]  rxd;
    logic        txv;
    logic [7:0]  txd;
    wire  [7:0]  data_bus;
    logic        tb_drive;
    logic [7:0]  tb_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] v;
    vec_t vecs [19];

    always #5 clk = ~clk;

    assign data_bus = tb_drive ? tb_data : {8{1'bz}};

    redbus_console #(.DEVICE_ID(8'h01), .RX_DEPTH(16), .TX_DEPTH(16)) dut (
        .Clock        (clk),
        .Reset        (rst_n),
        .Address      (addr),
        .Data         (data_bus),
        .RedbusDevice (dev),
        .Read         (rd),
        .Write        (wr),
        .RxStrobe     (rxs),
        .RxData       (rxd),
        .TxValid      (txv),
        .TxData       (txd),
        .TxReady      (txr)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Upper address byte is non-zero to confirm only Address[7:0] decodes.
    task automatic bus_read(input logic [7:0] a, input logic [7:0] d,
                            input bit keeper, output logic [7:0] val);
        addr = {8'hA5, a};
        dev  = d;
        rd   = 1'b1;
        if (keeper) begin
            tb_drive = 1'b1;
            tb_data  = 8'h00;
        end
        @(negedge clk);
        val = data_bus;
        sync();
        rd       = 1'b0;
        tb_drive = 1'b0;
        sync();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input logic [7:0] w);
        addr     = {8'h5A, a};
        dev      = d;
        tb_drive = 1'b1;
        tb_data  = w;
        wr       = 1'b1;
        sync();
        wr       = 1'b0;
        tb_drive = 1'b0;
        sync();
    endtask

    task automatic rx_push(input logic [7:0] b);
        rxs = 1'b1;
        rxd = b;
        sync();
        rxs = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] r;
        bus_read(a, 8'h01, 1'b0, r);
        check8(name, r, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_RD, 8'h00, 8'h01, 8'h00, 8'h00};
        vecs[1]  = '{OP_RU, 8'h00, 8'h02, 8'h00, 8'h00};
        vecs[2]  = '{OP_RX, 8'h00, 8'h00, 8'h41, 8'h00};
        vecs[3]  = '{OP_RX, 8'h00, 8'h00, 8'h42, 8'h00};
        vecs[4]  = '{OP_RU, 8'h00, 8'h02, 8'h00, 8'h00};
        vecs[5]  = '{OP_RD, 8'h00, 8'h01, 8'h00, 8'h01};
        vecs[6]  = '{OP_RD, 8'h01, 8'h01, 8'h00, 8'h02};
        vecs[7]  = '{OP_RU, 8'h02, 8'h02, 8'h00, 8'h00};
        vecs[8]  = '{OP_RD, 8'h02, 8'h01, 8'h00, 8'h41};
        vecs[9]  = '{OP_RD, 8'h02, 8'h01, 8'h00, 8'h42};
        vecs[10] = '{OP_RD, 8'h02, 8'h01, 8'h00, 8'h00};
        vecs[11] = '{OP_RD, 8'h01, 8'h01, 8'h00, 8'h00};
        vecs[12] = '{OP_RD, 8'h00, 8'h01, 8'h00, 8'h00};
        vecs[13] = '{OP_WR, 8'h03, 8'h02, 8'h55, 8'h00};
        vecs[14] = '{OP_RD, 8'h04, 8'h01, 8'h00, 8'h00};
        vecs[15] = '{OP_RD, 8'h03, 8'h01, 8'h00, 8'h00};
        vecs[16] = '{OP_RD, 8'h07, 8'h01, 8'h00, 8'h00};
        vecs[17] = '{OP_WR, 8'h07, 8'h01, 8'hFF, 8'h00};
        vecs[18] = '{OP_RD, 8'h00, 8'h01, 8'h00, 8'h00};

        rst_n = 1'b0; addr = '0; dev = '0; rd = 0; wr = 0;
        rxs = 0; rxd = '0; txr = 0; tb_drive = 0; tb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check8("reset_txvalid", {7'b0, txv}, 8'h00);
        check8("reset_txdata", txd, 8'h00);
        rst_n = 1'b1;
        sync();
        sync();

        // Table-driven decode / match / RX FIFO order.
        for (int i = 0; i < 19; i++) begin
            case (vecs[i].op)
                OP_RD: begin
                    bus_read(vecs[i].a, vecs[i].dev, 1'b0, v);
                    check8($sformatf("vec%0d_read", i), v, vecs[i].exp);
                end
                OP_RU: begin
                    bus_read(vecs[i].a, vecs[i].dev, 1'b1, v);
                    check8($sformatf("vec%0d_unmatched", i), v, vecs[i].exp);
                end
                OP_WR: bus_write(vecs[i].a, vecs[i].dev, vecs[i].wd);
                default: rx_push(vecs[i].wd);
            endcase
        end

        // Read held for 3 cycles: one pop, stable data.
        rx_push(8'h41);
        rx_push(8'h42);
        addr = 16'h0002; dev = 8'h01; rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check8($sformatf("hold_read_cyc%0d", i), data_bus, 8'h41);
            sync();
        end
        rd = 1'b0;
        sync();
        rd_chk("hold_rxcount", 8'h01, 8'h01);
        rd_chk("hold_next_byte", 8'h02, 8'h42);
        rd_chk("hold_rxcount_empty", 8'h01, 8'h00);

        // TX fill to 16, 17th dropped.
        for (int i = 0; i < 17; i++) bus_write(8'h03, 8'h01, 8'(8'h10 + i));
        @(negedge clk);
        check8("tx_valid_full", {7'b0, txv}, 8'h01);
        check8("tx_head_full", txd, 8'h10);
        sync();
        rd_chk("txcount_full", 8'h04, 8'h10);
        rd_chk("status_txfull_drop", 8'h00, 8'h0A);
        bus_write(8'h00, 8'h01, 8'h00);
        rd_chk("status_after_clear", 8'h00, 8'h02);

        // Push into full TX while downstream pops: accepted.
        addr = 16'h0003; dev = 8'h01; tb_drive = 1'b1; tb_data = 8'h30;
        wr = 1'b1; txr = 1'b1;
        sync();
        wr = 1'b0; txr = 1'b0; tb_drive = 1'b0;
        sync();
        rd_chk("txcount_push_pop", 8'h04, 8'h10);
        rd_chk("status_push_pop", 8'h00, 8'h02);

        txr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check8($sformatf("tx_drain%0d_valid", i), {7'b0, txv}, 8'h01);
            check8($sformatf("tx_drain%0d_data", i), txd, (i < 15) ? 8'(8'h11 + i) : 8'h30);
            sync();
        end
        @(negedge clk);
        check8("tx_empty_valid", {7'b0, txv}, 8'h00);
        check8("tx_empty_data", txd, 8'h00);
        sync();
        txr = 1'b0;

        // RX overflow and push coincident with pop on a full FIFO.
        for (int i = 0; i < 17; i++) rx_push(8'(8'h60 + i));
        rd_chk("status_rx_ovf", 8'h00, 8'h05);
        rd_chk("rxcount_full", 8'h01, 8'h10);
        addr = 16'h0002; dev = 8'h01; rd = 1'b1; rxs = 1'b1; rxd = 8'h99;
        @(negedge clk);
        check8("coincident_read", data_bus, 8'h60);
        sync();
        rd = 1'b0; rxs = 1'b0;
        sync();
        rd_chk("rxcount_coincident", 8'h01, 8'h10);
        rd_chk("status_coincident", 8'h00, 8'h05);
        bus_write(8'h00, 8'h01, 8'h00);
        rd_chk("status_rx_cleared", 8'h00, 8'h01);
        for (int i = 0; i < 15; i++) rd_chk($sformatf("rx_drain%0d", i), 8'h02, 8'(8'h61 + i));
        rd_chk("rx_drain_coincident", 8'h02, 8'h99);
        rd_chk("rx_drain_empty", 8'h02, 8'h00);
        rd_chk("rxcount_drained", 8'h01, 8'h00);

        // Reset asserted mid-write-strobe, released while still held.
        rx_push(8'h33);
        addr = 16'h0003; dev = 8'h01; tb_drive = 1'b1; tb_data = 8'h77; wr = 1'b1;
        sync();
        #2 rst_n = 1'b0;
        #1;
        check8("midreset_txvalid", {7'b0, txv}, 8'h00);
        sync();
        rst_n = 1'b1;
        sync();
        sync();
        wr = 1'b0; tb_drive = 1'b0;
        sync();
        rd_chk("midreset_txcount", 8'h04, 8'h00);
        rd_chk("midreset_rxcount", 8'h01, 8'h00);
        rd_chk("midreset_status", 8'h00, 8'h00);

`ifdef REDBUS_CONSOLE_LOOPBACK_EN
        bus_write(8'h05, 8'h01, 8'h01);
        rd_chk("ctrl_readback", 8'h05, 8'h01);
        addr = 16'h0003; dev = 8'h01; tb_drive = 1'b1; tb_data = 8'h55; wr = 1'b1;
        sync();
        wr = 1'b0; tb_drive = 1'b0;
        @(negedge clk);
        check8("loopback_txvalid", {7'b0, txv}, 8'h00);
        sync();
        sync();
        rd_chk("loopback_rxdata", 8'h02, 8'h55);
        rd_chk("loopback_txcount", 8'h04, 8'h00);
`else
        bus_write(8'h05, 8'h01, 8'h01);
        rd_chk("ctrl_disabled", 8'h05, 8'h00);
        bus_write(8'h03, 8'h01, 8'h55);
        @(negedge clk);
        check8("no_loopback_txvalid", {7'b0, txv}, 8'h01);
        check8("no_loopback_txdata", txd, 8'h55);
        sync();
        rd_chk("no_loopback_rxcount", 8'h01, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
